axis_m_pktgen: RTL and testbench

//  Parametrised AXI-Stream master packet generator; successor to the single-packet stream master.

---
 rtl/axis_m_pktgen.sv | 128 ++++++++++++
 tb/tb_axis_m_pktgen.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_m_pktgen.sv
// AXI-Stream master packet generator with a small command FIFO.
// Each queued command becomes one len+1 beat packet, back-to-back.
module axis_m_pktgen #(
    parameter int DATA_W    = 8,
    parameter int LEN_W     = 8,
    parameter int CMD_DEPTH = 4
) (
    input  logic              m_axis_aclk,
    input  logic              m_axis_areset,
    input  logic              newd,
    input  logic [DATA_W-1:0] din,
    input  logic [LEN_W-1:0]  len,
    input  logic              mode,
    output logic              cmd_ready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              pkt_done
);

    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CMD_W = DATA_W + LEN_W + 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t state;

    logic [CMD_W-1:0] mem [CMD_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic              hs;
    logic              last_beat;
    logic [DATA_W-1:0] head_din;
    logic [LEN_W-1:0]  head_len;
    logic              head_mode;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_cnt;
    logic [LEN_W-1:0]  beat_nx;
    logic              mode_q;

    assign empty     = (count == '0);
    assign full      = (count == (PTR_W+1)'(CMD_DEPTH));
    // Ready depends only on stored occupancy, so a pop cannot open a slot early.
    assign cmd_ready = !full && !m_axis_areset;
    assign push      = newd && cmd_ready;
    assign hs        = m_axis_tvalid && m_axis_tready;
    assign last_beat = (beat_cnt == len_q);
    assign beat_nx   = beat_cnt + 1'b1;
    assign pop       = !empty && ((state == IDLE) || (hs && last_beat));
    assign busy      = (state == SEND) || !empty;

    assign {head_mode, head_len, head_din} = mem[rd_ptr];

    always_ff @(posedge m_axis_aclk) begin
        if (push) begin
            mem[wr_ptr] <= {mode, len, din};
        end
    end

    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset) begin
            state         <= IDLE;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            pkt_done      <= 1'b0;
            beat_cnt      <= '0;
            len_q         <= '0;
            mode_q        <= 1'b0;
        end else begin
            pkt_done <= hs && last_beat;
            if (pop) begin
                // Covers both the idle start and a chained start after tlast.
                state         <= SEND;
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= head_din;
                m_axis_tlast  <= (head_len == '0);
                beat_cnt      <= '0;
                len_q         <= head_len;
                mode_q        <= head_mode;
            end else if (hs) begin
                if (last_beat) begin
                    state         <= IDLE;
                    m_axis_tvalid <= 1'b0;
                    m_axis_tlast  <= 1'b0;
                end else begin
                    beat_cnt     <= beat_nx;
                    m_axis_tlast <= (beat_nx == len_q);
                    if (!mode_q) begin
                        m_axis_tdata <= m_axis_tdata + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_m_pktgen.sv
// Bench for axis_m_pktgen: vector table, directed corner sequences,
// and a random phase checked by a beat-queue reference model.
module tb_axis_m_pktgen;

    logic       clk = 1'b0;
    logic       areset = 1'b1;
    logic       newd = 1'b1;
    logic [7:0] din = 8'h00;
    logic [7:0] len = 8'h00;
    logic       mode = 1'b0;
    logic       cmd_ready;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready = 1'b0;
    logic       tlast;
    logic       busy;
    logic       pkt_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axis_m_pktgen #(
        .DATA_W(8),
        .LEN_W(8),
        .CMD_DEPTH(4)
    ) dut (
        .m_axis_aclk(clk),
        .m_axis_areset(areset),
        .newd(newd),
        .din(din),
        .len(len),
        .mode(mode),
        .cmd_ready(cmd_ready),
        .m_axis_tdata(tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .m_axis_tlast(tlast),
        .busy(busy),
        .pkt_done(pkt_done)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [7:0] d, input logic [7:0] l,
                            input logic m);
        newd = 1'b1;
        din  = d;
        len  = l;
        mode = m;
        tick();
        newd = 1'b0;
    endtask

    // Reference model: every accepted command expands into its beats.
    logic [8:0] exp_q[$];
    logic [8:0] e;
    logic       pend_done = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    always @(negedge clk) begin
        if (areset) begin
            exp_q.delete();
            pend_done  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("busy", 32'(busy), 32'(exp_q.size() != 0));
            chk("pkt_done", 32'(pkt_done), 32'(pend_done));
            if (prev_stall) begin
                chk("hold_valid", 32'(tvalid), 32'd1);
                chk("hold_data", 32'(tdata), 32'(prev_data));
                chk("hold_last", 32'(tlast), 32'(prev_last));
            end
            pend_done = 1'b0;
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_beat", 32'(tdata), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 32'(tdata), 32'(e[7:0]));
                    chk("beat_last", 32'(tlast), 32'(e[8]));
                end
                pend_done = tlast;
            end
            if (newd && cmd_ready) begin
                for (int i = 0; i <= int'(len); i++) begin
                    exp_q.push_back({i == int'(len),
                                     mode ? din : din + 8'(i)});
                end
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
        end
    end

    typedef struct {
        logic [7:0] din;
        logic [7:0] len;
        logic       mode;
        logic [7:0] exp_last;
        int         exp_beats;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int nb;
        int hs;
        int nl;
        logic [7:0] first_d;
        logic [7:0] last_d;
        logic done;
        logic [7:0] t4_data[8];
        logic       t4_last[8];

        vecs[0] = '{8'h10, 8'd3,   1'b0, 8'h13, 4};
        vecs[1] = '{8'hFE, 8'd3,   1'b0, 8'h01, 4};
        vecs[2] = '{8'hA5, 8'd2,   1'b1, 8'hA5, 3};
        vecs[3] = '{8'h00, 8'd0,   1'b0, 8'h00, 1};
        vecs[4] = '{8'h7F, 8'd0,   1'b1, 8'h7F, 1};
        vecs[5] = '{8'hF0, 8'hFF,  1'b0, 8'hEF, 256};
        vecs[6] = '{8'h3C, 8'hFF,  1'b1, 8'h3C, 256};

        // T1: reset held with newd asserted
        repeat (5) tick();
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tdata", 32'(tdata), 32'd0);
        chk("rst_tlast", 32'(tlast), 32'd0);
        chk("rst_pkt_done", 32'(pkt_done), 32'd0);
        areset = 1'b0;
        newd   = 1'b0;
        #1;
        chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        chk("rel_busy", 32'(busy), 32'd0);
        chk("rel_tvalid", 32'(tvalid), 32'd0);

        // T2: latency and a single 4-beat packet
        tready = 1'b1;
        push_cmd(8'h10, 8'd3, 1'b0);
        chk("t2_lat_low", 32'(tvalid), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t2_valid", 32'(tvalid), 32'd1);
            chk("t2_data", 32'(tdata), 32'(8'h10 + 8'(i)));
            chk("t2_last", 32'(tlast), 32'(i == 3));
            tick();
        end
        chk("t2_done", 32'(pkt_done), 32'd1);
        chk("t2_idle", 32'(tvalid), 32'd0);
        tick();
        chk("t2_done_pulse", 32'(pkt_done), 32'd0);

        // Vector table, tready held high
        foreach (vecs[k]) begin
            push_cmd(vecs[k].din, vecs[k].len, vecs[k].mode);
            nb = 0;
            done = 1'b0;
            first_d = 8'h00;
            last_d = 8'h00;
            for (int c = 0; c < 300 && !done; c++) begin
                tick();
                if (tvalid && tready) begin
                    if (nb == 0) first_d = tdata;
                    nb++;
                    last_d = tdata;
                    if (tlast) done = 1'b1;
                end
            end
            chk("vec_timeout", 32'(done), 32'd1);
            chk("vec_beats", 32'(nb), 32'(vecs[k].exp_beats));
            chk("vec_first", 32'(first_d), 32'(vecs[k].din));
            chk("vec_last", 32'(last_d), 32'(vecs[k].exp_last));
            tick();
            tick();
            chk("vec_busy", 32'(busy), 32'd0);
        end

        // T3: backpressure 1,0,0 pattern, constant mode
        push_cmd(8'hA5, 8'd2, 1'b1);
        hs = 0;
        nl = 0;
        for (int c = 0; c < 30; c++) begin
            tready = (c % 3 == 0);
            #1;
            if (tvalid && tready) begin
                hs++;
                if (tlast) nl++;
                chk("t3_data", 32'(tdata), 32'hA5);
            end
            tick();
        end
        chk("t3_handshakes", 32'(hs), 32'd3);
        chk("t3_tlasts", 32'(nl), 32'd1);

        // T4: fill while stalled, then drain back-to-back
        tready = 1'b0;
        push_cmd(8'h20, 8'd0, 1'b0);
        push_cmd(8'h30, 8'd1, 1'b0);
        push_cmd(8'h40, 8'd0, 1'b0);
        push_cmd(8'h50, 8'd2, 1'b0);
        // The first command is already in flight, so one slot remains.
        chk("t4_ready_4", 32'(cmd_ready), 32'd1);
        push_cmd(8'h60, 8'd0, 1'b0);
        chk("t4_full", 32'(cmd_ready), 32'd0);
        tick();
        tick();
        chk("t4_still_full", 32'(cmd_ready), 32'd0);
        chk("t4_stall_valid", 32'(tvalid), 32'd1);
        chk("t4_stall_data", 32'(tdata), 32'h20);
        t4_data = '{8'h20, 8'h30, 8'h31, 8'h40, 8'h50, 8'h51, 8'h52, 8'h60};
        t4_last = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t4_valid", 32'(tvalid), 32'd1);
            chk("t4_data", 32'(tdata), 32'(t4_data[i]));
            chk("t4_last", 32'(tlast), 32'(t4_last[i]));
            tick();
        end
        chk("t4_end_busy", 32'(busy), 32'd0);
        tick();

        // T6: reset in the middle of a 10-beat packet
        push_cmd(8'h00, 8'd9, 1'b0);
        tick();
        chk("t6_start", 32'(tvalid), 32'd1);
        push_cmd(8'h77, 8'd1, 1'b0);
        repeat (3) tick();
        chk("t6_mid_data", 32'(tdata), 32'h04);
        areset = 1'b1;
        tick();
        chk("t6_tvalid", 32'(tvalid), 32'd0);
        chk("t6_tlast", 32'(tlast), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_tdata", 32'(tdata), 32'd0);
        chk("t6_cmd_ready", 32'(cmd_ready), 32'd0);
        areset = 1'b0;
        #1;
        chk("t6_rel_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_lost_cmd", 32'(tvalid), 32'd0);
        end

        // Random traffic against the beat-queue model
        for (int c = 0; c < 4000; c++) begin
            newd   = ($urandom_range(0, 3) == 0);
            din    = 8'($urandom);
            len    = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 63))
                                                  : 8'($urandom_range(0, 3));
            mode   = 1'($urandom_range(0, 1));
            tready = ($urandom_range(0, 3) != 0);
            tick();
        end
        newd   = 1'b0;
        tready = 1'b1;
        done   = 1'b0;
        for (int c = 0; c < 20000 && !done; c++) begin
            tick();
            if (!busy) done = 1'b1;
        end
        chk("rand_drain", 32'(done), 32'd1);
        tick();
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
